// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation
// encodings carried on op_i and the control FSM state encoding.
package muldiv_pkg;

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PREP  = 2'd1,
        ST_CALC  = 2'd2,
        ST_FIXUP = 2'd3
    } state_t;

    // True for either divide encoding.
    function automatic logic op_is_div(input logic [1:0] op);
        return (op == OP_DIVU) || (op == OP_DIV);
    endfunction

    // True for the encodings that carry signed operands.
    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the multiply/divide datapath (purely combinational).
//   i_is_div : 1 = restoring-divide step, 0 = shift-add multiply step
//   i_acc    : upper working register (partial product high / partial remainder)
//   i_q      : lower working register (multiplier bits / dividend-quotient bits)
//   i_m      : multiplicand (multiply) or divisor (divide), magnitude only
//   o_acc    : next upper working register
//   o_q      : next lower working register
module muldiv_step #(
    parameter int unsigned XLEN = 32
) (
    input  logic            i_is_div,
    input  logic [XLEN-1:0] i_acc,
    input  logic [XLEN-1:0] i_q,
    input  logic [XLEN-1:0] i_m,
    output logic [XLEN-1:0] o_acc,
    output logic [XLEN-1:0] o_q
);

    logic [XLEN:0] w_sum;
    logic [XLEN:0] w_shift;
    logic [XLEN:0] w_diff;
    logic          w_qbit;

    always_comb begin
        w_sum   = '0;
        w_shift = '0;
        w_diff  = '0;
        w_qbit  = 1'b0;
        o_acc   = i_acc;
        o_q     = i_q;
        if (i_is_div) begin
            // Bring the next dividend bit into the partial remainder and
            // keep the subtraction only if it does not go negative.
            w_shift = {i_acc, i_q[XLEN-1]};
            w_qbit  = (w_shift >= {1'b0, i_m});
            w_diff  = w_shift - {1'b0, i_m};
            o_acc   = w_qbit ? XLEN'(w_diff) : XLEN'(w_shift);
            o_q     = {i_q[XLEN-2:0], w_qbit};
        end else begin
            // Conditionally add the multiplicand, then shift the whole
            // {acc, q} pair right by one, carry included.
            w_sum = i_q[0] ? ({1'b0, i_acc} + {1'b0, i_m}) : {1'b0, i_acc};
            o_acc = w_sum[XLEN:1];
            o_q   = {w_sum[0], i_q[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MIPS-style HI/LO multiply/divide unit, one bit per cycle.
//   clk_i, rst_i         : clock, asynchronous active-low reset
//   start_i, op_i        : begin an op (sampled in IDLE); MULTU/MULT/DIVU/DIV
//   a_i, b_i             : rs / rt operands
//   flush_i              : abort the op in flight
//   hi_we_i, lo_we_i     : direct HI/LO writes from wdata_i while not busy
//   busy_o               : op in flight
//   done_o, div_zero_o   : commit pulse, divide-by-zero flag with it
//   hi_o, lo_o           : architectural HI/LO registers
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter bit          SIGNED_EN = 1'b1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic            flush_i,
    input  logic            hi_we_i,
    input  logic            lo_we_i,
    input  logic [XLEN-1:0] wdata_i,
    output logic            busy_o,
    output logic            done_o,
    output logic            div_zero_o,
    output logic [XLEN-1:0] hi_o,
    output logic [XLEN-1:0] lo_o
);

    localparam int unsigned CNT_W = $clog2(XLEN);
    localparam int unsigned PW    = 2 * XLEN;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [1:0]        r_op;
    logic [XLEN-1:0]   r_a_raw;
    logic [XLEN-1:0]   r_b_raw;
    logic [XLEN-1:0]   r_acc;
    logic [XLEN-1:0]   r_q;
    logic [XLEN-1:0]   r_m;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_neg_q;
    logic              r_neg_r;
    logic              r_busy;
    logic              r_done;
    logic              r_dz;
    logic [XLEN-1:0]   r_hi;
    logic [XLEN-1:0]   r_lo;

    logic              w_busy_nxt;
    logic              w_done_nxt;
    logic              w_dz_nxt;
    logic [XLEN-1:0]   w_hi_nxt;
    logic [XLEN-1:0]   w_lo_nxt;

    logic              w_is_div;
    logic              w_is_signed;
    logic              w_neg_a;
    logic              w_neg_b;
    logic [XLEN-1:0]   w_abs_a;
    logic [XLEN-1:0]   w_abs_b;
    logic              w_b_zero;
    logic [XLEN-1:0]   w_acc_step;
    logic [XLEN-1:0]   w_q_step;
    logic [PW-1:0]     w_prod;
    logic [PW-1:0]     w_prod_fix;
    logic [XLEN-1:0]   w_quo;
    logic [XLEN-1:0]   w_rem;
    logic [XLEN-1:0]   w_hi_fix;
    logic [XLEN-1:0]   w_lo_fix;

    assign busy_o     = r_busy;
    assign done_o     = r_done;
    assign div_zero_o = r_dz;
    assign hi_o       = r_hi;
    assign lo_o       = r_lo;

    // Operand decode on the latched request; with SIGNED_EN=0 every op is unsigned.
    assign w_is_div    = op_is_div(r_op);
    assign w_is_signed = SIGNED_EN && op_is_signed(r_op);
    assign w_neg_a     = w_is_signed && r_a_raw[XLEN-1];
    assign w_neg_b     = w_is_signed && r_b_raw[XLEN-1];
    assign w_abs_a     = w_neg_a ? -r_a_raw : r_a_raw;
    assign w_abs_b     = w_neg_b ? -r_b_raw : r_b_raw;
    assign w_b_zero    = (r_b_raw == '0);

    muldiv_step #(
        .XLEN (XLEN)
    ) u_step (
        .i_is_div (w_is_div),
        .i_acc    (r_acc),
        .i_q      (r_q),
        .i_m      (r_m),
        .o_acc    (w_acc_step),
        .o_q      (w_q_step)
    );

    // Sign correction of the unsigned magnitude result.
    assign w_prod     = {r_acc, r_q};
    assign w_prod_fix = r_neg_q ? -w_prod : w_prod;
    assign w_quo      = r_neg_q ? -r_q : r_q;
    assign w_rem      = r_neg_r ? -r_acc : r_acc;

    // Result committed in FIXUP; divide by zero bypasses the iteration result.
    always_comb begin
        w_hi_fix = w_prod_fix[PW-1:XLEN];
        w_lo_fix = w_prod_fix[XLEN-1:0];
        if (w_is_div) begin
            if (w_b_zero) begin
                w_hi_fix = r_a_raw;
                w_lo_fix = '1;
            end else begin
                w_hi_fix = w_rem;
                w_lo_fix = w_quo;
            end
        end
    end

    // Control FSM state and registered outputs.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_dz    <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_dz    <= w_dz_nxt;
            r_hi    <= w_hi_nxt;
            r_lo    <= w_lo_nxt;
        end
    end

    // Next state and next output values.
    always_comb begin
        w_state_nxt = r_state;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_dz_nxt    = 1'b0;
        w_hi_nxt    = r_hi;
        w_lo_nxt    = r_lo;

        if (!r_busy && hi_we_i) w_hi_nxt = wdata_i;
        if (!r_busy && lo_we_i) w_lo_nxt = wdata_i;

        case (r_state)
            ST_IDLE: begin
                if (start_i && !flush_i) begin
                    w_state_nxt = ST_PREP;
                    w_busy_nxt  = 1'b1;
                end
            end
            ST_PREP: w_state_nxt = ST_CALC;
            ST_CALC: begin
                if (r_cnt == '0) w_state_nxt = ST_FIXUP;
            end
            ST_FIXUP: begin
                w_state_nxt = ST_IDLE;
                w_busy_nxt  = 1'b0;
                w_done_nxt  = 1'b1;
                w_dz_nxt    = w_is_div && w_b_zero;
                w_hi_nxt    = w_hi_fix;
                w_lo_nxt    = w_lo_fix;
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        // Flush abandons the op without touching HI/LO or pulsing done.
        if (flush_i && (r_state != ST_IDLE)) begin
            w_state_nxt = ST_IDLE;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b0;
            w_dz_nxt    = 1'b0;
            w_hi_nxt    = r_hi;
            w_lo_nxt    = r_lo;
        end
    end

    // Operand latch, working registers and iteration counter.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_op    <= OP_MULTU;
            r_a_raw <= '0;
            r_b_raw <= '0;
            r_acc   <= '0;
            r_q     <= '0;
            r_m     <= '0;
            r_cnt   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start_i && !flush_i) begin
                        r_op    <= op_i;
                        r_a_raw <= a_i;
                        r_b_raw <= b_i;
                    end
                end
                ST_PREP: begin
                    r_acc   <= '0;
                    r_q     <= w_is_div ? w_abs_a : w_abs_b;
                    r_m     <= w_is_div ? w_abs_b : w_abs_a;
                    r_neg_q <= w_neg_a ^ w_neg_b;
                    r_neg_r <= w_neg_a;
                    r_cnt   <= CNT_W'(XLEN - 1);
                end
                ST_CALC: begin
                    r_acc <= w_acc_step;
                    r_q   <= w_q_step;
                    if (r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule
